// File: rtl/pong_match_ctrl.sv
// Match sequencer for Pong: serve/play/point pacing, scoring and winner detection.
// Optional macro PONG_AUTO_RESTART_EN returns GAME_OVER to IDLE after RESTART_TICKS frame ticks.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned SERVE_TICKS = 60,
  parameter int unsigned POINT_TICKS = 90,
  parameter int unsigned TICK_W      = 8
`ifdef PONG_AUTO_RESTART_EN
  ,
  parameter int unsigned RESTART_TICKS = 240
`endif
) (
  input  logic               CLOCK_25,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_enable,
  output logic               ball_reload,
  output logic               serve_left,
  output logic [SCORE_W-1:0] score_1,
  output logic [SCORE_W-1:0] score_2,
  output logic [1:0]         winner,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StServe    = 3'd1,
    StPlay     = 3'd2,
    StPoint    = 3'd3,
    StGameOver = 3'd4
  } state_e;

  localparam logic [SCORE_W-1:0] WinScore = SCORE_W'(WIN_SCORE);

  state_e             state_q, state_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [SCORE_W-1:0] score_1_q, score_1_d, score_2_q, score_2_d;
  logic [1:0]         winner_q, winner_d;
  logic               serve_left_q, serve_left_d;
  logic               ball_enable_q, ball_enable_d;
  logic               ball_reload_q, ball_reload_d;

  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state_q       <= StIdle;
      tick_q        <= '0;
      score_1_q     <= '0;
      score_2_q     <= '0;
      winner_q      <= 2'b00;
      serve_left_q  <= 1'b0;
      ball_enable_q <= 1'b0;
      ball_reload_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      score_1_q     <= score_1_d;
      score_2_q     <= score_2_d;
      winner_q      <= winner_d;
      serve_left_q  <= serve_left_d;
      ball_enable_q <= ball_enable_d;
      ball_reload_q <= ball_reload_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tick_d        = tick_q;
    score_1_d     = score_1_q;
    score_2_d     = score_2_q;
    winner_d      = winner_q;
    serve_left_d  = serve_left_q;
    ball_reload_d = 1'b0;

    case (state_q)
      StIdle: begin
        score_1_d = '0;
        score_2_d = '0;
        winner_d  = 2'b00;
        if (start) begin
          state_d       = StServe;
          ball_reload_d = 1'b1;
        end
      end
      StServe: begin
        if (frame_tick) begin
          if (tick_q == TICK_W'(SERVE_TICKS - 1)) state_d = StPlay;
          else                                    tick_d  = tick_q + TICK_W'(1);
        end
      end
      StPlay: begin
        if (miss_left && miss_right) begin
          // Simultaneous misses are a void rally: re-serve without scoring.
          state_d       = StServe;
          ball_reload_d = 1'b1;
        end else if (miss_left) begin
          if (score_2_q < WinScore) score_2_d = score_2_q + SCORE_W'(1);
          serve_left_d = 1'b1;
          state_d      = StPoint;
        end else if (miss_right) begin
          if (score_1_q < WinScore) score_1_d = score_1_q + SCORE_W'(1);
          serve_left_d = 1'b0;
          state_d      = StPoint;
        end
      end
      StPoint: begin
        if (frame_tick) begin
          if (tick_q == TICK_W'(POINT_TICKS - 1)) begin
            if (score_1_q == WinScore) begin
              winner_d = 2'b01;
              state_d  = StGameOver;
            end else if (score_2_q == WinScore) begin
              winner_d = 2'b10;
              state_d  = StGameOver;
            end else begin
              state_d       = StServe;
              ball_reload_d = 1'b1;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
      StGameOver: begin
        if (start) begin
          score_1_d     = '0;
          score_2_d     = '0;
          winner_d      = 2'b00;
          serve_left_d  = 1'b0;
          state_d       = StServe;
          ball_reload_d = 1'b1;
        end
`ifdef PONG_AUTO_RESTART_EN
        else if (frame_tick) begin
          if (tick_q == TICK_W'(RESTART_TICKS - 1)) begin
            score_1_d = '0;
            score_2_d = '0;
            winner_d  = 2'b00;
            state_d   = StIdle;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
`else
        // Holds until start or reset.
`endif
      end
      default: state_d = StIdle;
    endcase

    // A tick coincident with a state change is not carried into the new state.
    if (state_d != state_q) tick_d = '0;
    ball_enable_d = (state_d == StPlay);
  end

  assign ball_enable = ball_enable_q;
  assign ball_reload = ball_reload_q;
  assign serve_left  = serve_left_q;
  assign score_1     = score_1_q;
  assign score_2     = score_2_q;
  assign winner      = winner_q;
  assign state       = state_q;

endmodule
